gin_mc_bus: RTL
===============

// Module: gin_mc_bus
// PURPOSE
//   Next-generation global input network bus: one tagged packet stream fans out to SLV_NUM slaves.
//   Each slave has a run-time ID, an enable bit and a FIFO_DEPTH output FIFO.
//   Supports unicast, multicast (several slaves share one ID) and a broadcast tag.
//   Multicast delivery is all-or-nothing. Sits between the top controller / global buffer and the PE array.
// PARAMETERS
//   ID_BITWIDTH    4   tag/ID width; tag = i_data[MSBs]
//   DATA_BITWIDTH  8   payload width delivered to each slave
//   SLV_NUM        6   number of slaves
//   FIFO_DEPTH     4   per-slave FIFO entries; power of 2, >=2
//   BCAST_ID       {ID_BITWIDTH{1'b1}}   tag matching every enabled slave
// PORTS
//   i_clk       in   1                          clock, rising edge
//   i_rst_n     in   1                          async active-low reset
//   i_data      in   ID_BITWIDTH+DATA_BITWIDTH  {tag, payload}
//   i_valid     in   1                          input packet valid
//   o_ready     out  1                          input packet accepted when i_valid&&o_ready
//   o_data      out  SLV_NUM*DATA_BITWIDTH      slave i payload = o_data[i*DATA_BITWIDTH +: DATA_BITWIDTH]
//   o_valid     out  SLV_NUM                    per-slave FIFO head valid
//   i_ready     in   SLV_NUM                    per-slave pop
//   i_id        in   SLV_NUM*ID_BITWIDTH        slave i ID = i_id[i*ID_BITWIDTH +: ID_BITWIDTH]
//   i_id_en     in   SLV_NUM                    slave enable mask, loaded with i_id
//   i_id_valid  in   1                          load ID and enable registers
//   o_drop_cnt  out  16                         count of dropped (unmatched) packets, saturating
// BEHAVIOUR
//   Reset (async, i_rst_n=0): ID regs=0, enables=0, all FIFOs empty, storage=0, o_drop_cnt=0.
//     Outputs while in reset: o_valid=0, o_data=0, o_ready=0. Reset mid-operation discards all queued data.
//   Config: on an edge with i_id_valid=1, ID and enable regs load. FIFOs are NOT flushed.
//     o_ready=0 in any cycle with i_id_valid=1; config takes precedence over packets.
//   Match: match[i] = en[i] && (tag==id[i] || tag==BCAST_ID). Uses registered IDs, never same-cycle i_id.
//   o_ready is combinational from the tag, match and FIFO full flags; it does not depend on i_valid.
//     o_ready = rst_n && !i_id_valid && (no i with match[i] && full[i]).
//     Full is evaluated before the same-cycle pop; a full FIFO blocks even if popped that cycle.
//   Accept (i_valid&&o_ready) with >=1 match:
//     Payload is pushed into every matching FIFO on that edge.
//     Non-matching FIFOs are untouched. All-or-nothing: never a partial multicast.
//   Accept with zero matches (includes all slaves disabled):
//     Packet is consumed and discarded.
//     o_drop_cnt += 1, saturating at 16'hFFFF.
//   Latency: payload accepted at edge N appears on o_valid/o_data right after edge N (cycle N+1).
//   Output side, per slave:
//     o_valid[i] = !empty[i]; o_data slice = FIFO head (first-word-fall-through).
//     Pop on o_valid[i]&&i_ready[i]; i_ready is ignored when empty.
//     Push and pop in the same cycle on a non-full, non-empty FIFO: count unchanged, order kept.
//   FIFO: wrap-around read/write pointers with an occupancy counter; full at FIFO_DEPTH entries.
//     No overflow or underflow is possible by construction.
//   Slaves are independent: a stalled slave blocks only packets whose tag matches it.
// TESTING
//   1 Config ID[i]=i, en=6'h3F; send {4'd2,8'hA5}, i_ready=6'h3F
//     -> o_ready=1; next cycle o_valid=6'b000100, o_data[23:16]=8'hA5; o_valid=0 after pop.
//   2 Send {BCAST_ID,8'h3C} -> all six o_valid set one cycle later, every slice=8'h3C.
//   3 i_ready[2]=0; send 4x tag 2 (8'h01..8'h04)
//     -> all accepted; 5th sees o_ready=0; after one pop o_ready=1; drain order 01,02,03,04,05.
//   4 ID[1]=ID[4]=7; FIFO4 full; send tag 7
//     -> o_ready=0 and FIFO1 untouched; pop slave 4 -> packet lands in both FIFOs the same edge.
//   5 Send tag 9 (unmatched) -> o_ready=1, o_valid stays 0, o_drop_cnt 0->1; force 16'hFFFF -> stays 16'hFFFF.
//   6 Assert i_rst_n=0 mid-stream with FIFOs non-empty
//     -> o_valid=0, o_ready=0 immediately; after release: en=0, tag 0 is dropped, not delivered.

Source files
------------

// File: rtl/gin_mc_bus.sv
// rtl/gin_mc_bus.sv - tagged packet bus fanning out to per-slave FWFT FIFOs
// Unicast, multicast and broadcast delivery; multicast is all-or-nothing.
module gin_mc_bus #(
  parameter int ID_BITWIDTH   = 4,
  parameter int DATA_BITWIDTH = 8,
  parameter int SLV_NUM       = 6,
  parameter int FIFO_DEPTH    = 4,
  parameter logic [ID_BITWIDTH-1:0] BCAST_ID = {ID_BITWIDTH{1'b1}}
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic [ID_BITWIDTH+DATA_BITWIDTH-1:0] i_data,
  input  logic                               i_valid,
  output logic                               o_ready,
  output logic [SLV_NUM*DATA_BITWIDTH-1:0]   o_data,
  output logic [SLV_NUM-1:0]                 o_valid,
  input  logic [SLV_NUM-1:0]                 i_ready,
  input  logic [SLV_NUM*ID_BITWIDTH-1:0]     i_id,
  input  logic [SLV_NUM-1:0]                 i_id_en,
  input  logic                               i_id_valid,
  output logic [15:0]                        o_drop_cnt
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [ID_BITWIDTH-1:0]   id_q   [SLV_NUM];
  logic [ID_BITWIDTH-1:0]   id_d   [SLV_NUM];
  logic [SLV_NUM-1:0]       en_q, en_d;
  logic [DATA_BITWIDTH-1:0] mem_q  [SLV_NUM][FIFO_DEPTH];
  logic [DATA_BITWIDTH-1:0] mem_d  [SLV_NUM][FIFO_DEPTH];
  logic [PTR_W-1:0]         rd_ptr_q [SLV_NUM];
  logic [PTR_W-1:0]         rd_ptr_d [SLV_NUM];
  logic [PTR_W-1:0]         wr_ptr_q [SLV_NUM];
  logic [PTR_W-1:0]         wr_ptr_d [SLV_NUM];
  logic [CNT_W-1:0]         cnt_q  [SLV_NUM];
  logic [CNT_W-1:0]         cnt_d  [SLV_NUM];
  logic [15:0]              drop_cnt_q, drop_cnt_d;

  logic [ID_BITWIDTH-1:0]   tag;
  logic [DATA_BITWIDTH-1:0] payload;
  logic [SLV_NUM-1:0]       match, full, push, pop;
  logic                     ready, accept;

  always_comb begin
    tag        = i_data[ID_BITWIDTH+DATA_BITWIDTH-1 -: ID_BITWIDTH];
    payload    = i_data[DATA_BITWIDTH-1:0];
    id_d       = id_q;
    en_d       = en_q;
    mem_d      = mem_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    cnt_d      = cnt_q;
    drop_cnt_d = drop_cnt_q;
    match      = '0;
    full       = '0;
    push       = '0;
    pop        = '0;

    if (i_id_valid) begin
      for (int i = 0; i < SLV_NUM; i++) id_d[i] = i_id[i*ID_BITWIDTH +: ID_BITWIDTH];
      en_d = i_id_en;
    end

    for (int i = 0; i < SLV_NUM; i++) begin
      match[i] = en_q[i] && ((tag == id_q[i]) || (tag == BCAST_ID));
      full[i]  = (cnt_q[i] == CNT_W'(FIFO_DEPTH));
    end

    // Full is sampled before any same-cycle pop, so one blocked slave stalls the whole packet.
    ready  = i_rst_n && !i_id_valid && ((match & full) == '0);
    accept = i_valid && ready;

    for (int i = 0; i < SLV_NUM; i++) begin
      push[i] = accept && match[i];
      pop[i]  = (cnt_q[i] != '0) && i_ready[i];
      if (push[i]) begin
        mem_d[i][wr_ptr_q[i]] = payload;
        wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(1);
      end
      if (pop[i]) rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(1);
      if (push[i] && !pop[i])      cnt_d[i] = cnt_q[i] + CNT_W'(1);
      else if (!push[i] && pop[i]) cnt_d[i] = cnt_q[i] - CNT_W'(1);
    end

    if (accept && (match == '0) && (drop_cnt_q != 16'hFFFF))
      drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_comb begin
    o_ready    = ready;
    o_drop_cnt = drop_cnt_q;
    o_valid    = '0;
    o_data     = '0;
    for (int i = 0; i < SLV_NUM; i++) begin
      o_valid[i] = (cnt_q[i] != '0);
      o_data[i*DATA_BITWIDTH +: DATA_BITWIDTH] = mem_q[i][rd_ptr_q[i]];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      en_q       <= '0;
      drop_cnt_q <= '0;
      for (int i = 0; i < SLV_NUM; i++) begin
        id_q[i]     <= '0;
        rd_ptr_q[i] <= '0;
        wr_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
        for (int j = 0; j < FIFO_DEPTH; j++) mem_q[i][j] <= '0;
      end
    end else begin
      en_q       <= en_d;
      drop_cnt_q <= drop_cnt_d;
      id_q       <= id_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      cnt_q      <= cnt_d;
      mem_q      <= mem_d;
    end
  end

endmodule
